// File: rtl/demux_feed_seq_if.sv
// demux_feed_seq_if: handshake input side and demux drive side of the feeder
interface demux_feed_seq_if #(parameter int CW = 8);
  logic [3:0] in_data;
  logic [2:0] in_ch;
  logic in_valid;
  logic in_ready;
  logic auto_rr;
  logic [3:0] A;
  logic [2:0] S;
  logic C4;
  logic busy;
  logic [CW-1:0] fifo_count;
  modport master(output in_data, in_ch, in_valid, auto_rr, input in_ready, A, S, C4, busy, fifo_count);
  modport slave(input in_data, in_ch, in_valid, auto_rr, output in_ready, A, S, C4, busy, fifo_count);
endinterface

// File: rtl/demux_feed_seq.sv
// demux_feed_seq: FIFO-buffered feeder holding each word on A/S with C4=1 for DWELL cycles.
// Optional sticky overflow flag (ovf/ovf_clr) when DEMUX_FEED_SEQ_OVF_EN is defined.
module demux_feed_seq #(
  parameter int DEPTH = 4,
  parameter int DWELL = 1,
  parameter int CW = 8
) (
  input logic clk,
  input logic rst,
`ifdef DEMUX_FEED_SEQ_OVF_EN
  input logic ovf_clr,
  output logic ovf,
`endif
  demux_feed_seq_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0, DRIVE = 1'b1;
  logic [6:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count, dwell;
  logic [0:0] state;
  logic [3:0] a;
  logic [2:0] s, rr;
  logic push, pop;
  assign bus.in_ready = count < CW'(DEPTH);
  assign push = bus.in_valid & bus.in_ready;
  // pop either from idle or exactly when the current word's dwell expires
  assign pop = (count != 0) & (state == IDLE | dwell == 0);
  assign bus.A = a;
  assign bus.S = s;
  assign bus.C4 = state == DRIVE;
  assign bus.busy = state == DRIVE | count != 0;
  assign bus.fifo_count = count;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {bus.in_ch, bus.in_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      dwell <= '0;
      state <= IDLE;
      a <= '0;
      s <= '0;
      rr <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + CW'(push) - CW'(pop);
      if (pop) begin
        state <= DRIVE;
        a <= mem[rp][3:0];
        s <= bus.auto_rr ? rr : mem[rp][6:4];
        dwell <= CW'(DWELL - 1);
        if (bus.auto_rr) rr <= rr + 3'd1;
      end else if (state == DRIVE) begin
        if (dwell != 0) dwell <= dwell - 1'b1;
        else begin
          state <= IDLE;
          a <= '0;
        end
      end
    end
  end
`ifdef DEMUX_FEED_SEQ_OVF_EN
  always_ff @(posedge clk)
    ovf <= rst ? 1'b0 : (bus.in_valid & ~bus.in_ready) ? 1'b1 : ovf_clr ? 1'b0 : ovf;
`endif
endmodule

// File: doc/demux_feed_seq.md
Name: demux_feed_seq

Overview:
- Upstream feeder for the 1-to-8 4-bit demultiplexer stage.
- Accepts 4-bit data words over a valid/ready handshake and buffers them in a small FIFO.
- Presents each word to the demux as data (A), select (S) and enable (C4) for a programmable dwell time.
- The channel comes either from the word's own tag or from an internal round-robin counter.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- DWELL, 1, cycles each word is held with C4=1; minimum 1.
- CW, 8, counter width for dwell and FIFO occupancy; must hold DEPTH and DWELL.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous active-high reset.
- in_data  in  4  data word to deliver.
- in_ch  in  3  target channel, used when auto_rr=0.
- in_valid  in  1  in_data/in_ch valid.
- in_ready  out  1  FIFO can accept a word.
- auto_rr  in  1  1 selects round-robin channel assignment.
- A  out  4  data to demux.
- S  out  3  channel select to demux.
- C4  out  1  demux enable.
- busy  out  1  a word is being driven, or the FIFO is non-empty.
- fifo_count  out  CW  current FIFO occupancy.

Behaviour:
- Reset: one clock, synchronous, active-high, sampled on the rising edge of clk.
  - A=0, S=0, C4=0, busy=0, fifo_count=0.
  - FIFO pointers cleared, round-robin counter=0, FSM in IDLE.
  - Reset mid-operation discards buffered and in-flight words. C4 is 0 the cycle after reset.
- FIFO:
  - Stores {in_ch, in_data}. in_ready = (fifo_count < DEPTH), combinational from registered count.
  - Push on any edge with in_valid & in_ready. in_valid while full is ignored, with no state change.
  - Simultaneous push and pop when full: the push is refused, because in_ready is already 0. There is no pass-through path.
  - Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo DEPTH.
- FSM states IDLE and DRIVE:
  - IDLE: C4=0, A=0, S holds its last value. If the FIFO is non-empty, pop at the edge: load A=data, assign S, set C4=1, dwell counter = DWELL-1, go to DRIVE.
  - DRIVE with dwell counter > 0: decrement; A, S and C4 are held.
  - DRIVE with dwell counter = 0 and FIFO non-empty: pop the next word back-to-back, so C4 stays 1 with no gap.
  - DRIVE with dwell counter = 0 and FIFO empty: C4=0, A=0, go to IDLE.
- Latency: a word pushed at edge k into an empty, idle block appears on A/S with C4=1 after edge k+1. It is held for exactly DWELL cycles.
- Channel assignment (auto_rr sampled at pop time):
  - auto_rr=0: S = stored in_ch.
  - auto_rr=1: S = rr counter; the counter then increments, wrapping 7 to 0. The counter advances only on auto_rr pops.
- busy = (state==DRIVE) | (fifo_count != 0).
- Throughput: one word per DWELL cycles sustained.

Optional Feature:
- Macro: DEMUX_FEED_SEQ_OVF_EN.
- When defined, adds two ports:
  - ovf_clr  in  1
  - ovf  out  1
- ovf is a sticky flag, set on any edge with in_valid=1 while in_ready=0.
- ovf is cleared by rst or ovf_clr. If set and clear occur in the same cycle, set wins.
- When not defined, the ports and logic are absent and dropped words go unreported.

Test Plan:
- Reset then idle, no in_valid: A=0, S=0, C4=0, in_ready=1, fifo_count=0, busy=0 for 10 cycles.
- DWELL=1, auto_rr=0, push {ch=5, data=4'hA} at edge k: after edge k+1, S=5, A=4'hA, C4=1 for one cycle, then C4=0, A=0.
- DWELL=3, auto_rr=1, push 10 words back-to-back:
  - S sequence is 0,1,…,7,0,1.
  - Each word is held 3 cycles with C4 continuously 1.
  - in_ready drops when fifo_count=4.
- Fill FIFO (DEPTH=4) while the FSM is stalled by DWELL=8, then assert in_valid with data 4'hF: word dropped, fifo_count stays 4. With DEMUX_FEED_SEQ_OVF_EN, ovf=1 until ovf_clr.
- Assert rst in the middle of a DWELL with 3 words queued: next cycle C4=0, fifo_count=0. After deassert, the next pushed word appears with S equal to its own tag, or S=0 with auto_rr=1.
- Push and pop on the same edge with fifo_count=2: fifo_count stays 2, and data order is preserved FIFO-wise.
